draw_line: RTL and testbench
============================

// Module: draw_line
// PURPOSE
//  Bresenham line rasterizer for the GPU raster path. Takes two endpoints and,
//  one get_pixel request at a time, presents successive integer pixel
//  coordinates from (x1,y1) to (x2,y2) inclusive. Covers all octants,
//  horizontal, vertical and single-point lines. Sits between the command
//  decoder and the frame-buffer writer.
// PARAMETERS
//  COORD_W  16  width of every coordinate port and coordinate register
// PORTS
//  clk            in   1        system clock, rising-edge
//  reset          in   1        asynchronous, active-high reset
//  calculate      in   1        load endpoints and (re)start a line
//  x1,y1          in   COORD_W  start point, unsigned
//  x2,y2          in   COORD_W  end point, unsigned
//  get_pixel      in   1        advance request; acts on its rising edge
//  x_o,y_o        out  COORD_W  current pixel, registered
//  line_complete  out  1        current pixel is the end point
// BEHAVIOUR
//  - One clock domain (clk). Reset is asynchronous, active-high.
//  - Reset values:
//    - x_o=0, y_o=0, line_complete=0, state=IDLE.
//    - All internal registers, including the get_pixel delay flop, clear to 0.
//  - States:
//    - IDLE: outputs hold.
//    - RUN: a line is active; the current pixel is on x_o/y_o.
//    - DONE: the end point is on x_o/y_o.
//  - Loading a line (calculate=1 at a clock edge, in any state):
//    - Latch x2,y2 and set x_o=x1, y_o=y1.
//    - Set dx=|x2-x1| and dy=-|y2-y1|, as (COORD_W+2)-bit signed values.
//    - Set sx=(x1<x2)?+1:-1 and sy=(y1<y2)?+1:-1.
//    - Set err=dx+dy.
//    - Next state: DONE if (x1,y1)==(x2,y2), otherwise RUN.
//    - The first pixel is valid on the cycle after the edge (latency 1).
//    - Holding calculate high re-loads on every cycle. calculate takes
//      priority over get_pixel in the same cycle.
//  - Edge detection: gp_rise = get_pixel & ~get_pixel_q, where get_pixel_q
//    is get_pixel registered. A request held high for N cycles advances
//    exactly one pixel.
//  - Step (state RUN, gp_rise=1), with e2 = 2*err:
//    - if e2 >= dy: err += dy and x_o += sx.
//    - if e2 <= dx: err += dx and y_o += sy.
//    - Both updates use the old err and apply in the same cycle; the new pixel
//      is visible on the next cycle.
//    - If the new pixel equals (x2,y2): go to DONE and set line_complete=1 in
//      the same cycle that pixel appears.
//  - Pixel count: exactly max(|dx|,|dy|) steps after the first pixel.
//    Coordinates never leave the closed box spanned by the endpoints, so no
//    wrap-around occurs.
//  - line_complete:
//    - Set to 1 whenever the state is DONE.
//    - Cleared to 0 by reset, or by a load whose endpoints differ.
//  - In DONE and IDLE, get_pixel is ignored; outputs hold.
//  - Reset mid-line aborts the line immediately; after release the block
//    waits in IDLE.
// STRUCTURE
//  - Shared package gpu_pkg holds:
//    - COORD_W;
//    - typedef coord_t = logic [COORD_W-1:0];
//    - typedef enum {IDLE, RUN, DONE} line_state_t.
//  - Sub-module bresenham_step: combinational; inputs err, dx, dy, sx, sy, x, y;
//    outputs next err, x, y. The FSM and registers stay in draw_line.
// TESTING  (1 step = one get_pixel pulse: 1 cycle high, 1 cycle low)
//  - (100,90)->(50,100):
//    - x_o falls by 1 every step; y_o rises 10 times in total, spread evenly.
//    - After step 50: (50,100) with line_complete=1.
//    - Further pulses leave the outputs unchanged.
//  - (90,100)->(100,50): steep line.
//    - y_o falls by 1 every step; x_o rises 10 times in total.
//    - After step 50: (100,50) with line_complete=1.
//  - (10,50)->(20,50): y_o stays 50, x_o runs 11..20. line_complete=1 only
//    after step 10.
//  - (10,5)->(10,5): line_complete=1 one cycle after calculate. get_pixel held
//    2 cycles, twice -> no change.
//  - (30,10)->(20,20): both coordinates change every step: (29,11), (28,12), ...
//    reaching (20,20) with line_complete=1 after step 10.
//  - Robustness:
//    - Assert reset mid-line -> outputs and line_complete go to 0 without a
//      clock edge.
//    - calculate while in RUN -> the line restarts at the new x1,y1.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared raster-path types and coordinate width.
package gpu_pkg;
  localparam int COORD_W = 16;
  localparam int ERR_W = COORD_W + 2;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic signed [ERR_W-1:0] err_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} line_state_t;
  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a < b) ? b - a : a - b;
  endfunction
endpackage

// File: rtl/bresenham_step.sv
// bresenham_step: one combinational Bresenham advance from the current pixel.
module bresenham_step
  import gpu_pkg::*;
(
  input  logic signed [ERR_W-1:0]   err,
  input  logic signed [ERR_W-1:0]   dx,
  input  logic signed [ERR_W-1:0]   dy,
  input  logic                      sx,
  input  logic                      sy,
  input  logic        [COORD_W-1:0] x,
  input  logic        [COORD_W-1:0] y,
  output logic signed [ERR_W-1:0]   err_n,
  output logic        [COORD_W-1:0] x_n,
  output logic        [COORD_W-1:0] y_n
);
  // One extra bit so doubling err cannot overflow before the comparisons.
  logic signed [ERR_W:0] e2;
  logic step_x, step_y;
  always_comb begin
    e2 = $signed({err, 1'b0});
    step_x = e2 >= dy;
    step_y = e2 <= dx;
    err_n = err + (step_x ? dy : err_t'(0)) + (step_y ? dx : err_t'(0));
    x_n = step_x ? (sx ? x + 1'b1 : x - 1'b1) : x;
    y_n = step_y ? (sy ? y + 1'b1 : y - 1'b1) : y;
  end
endmodule

// File: rtl/draw_line.sv
// draw_line: Bresenham line rasterizer, one pixel per get_pixel rising edge.
module draw_line
  import gpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               calculate,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  input  logic               get_pixel,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               line_complete
);
  line_state_t state_q, state_d;
  coord_t x_q, x_d, y_q, y_d, x2_q, x2_d, y2_q, y2_d;
  err_t dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic sx_q, sx_d, sy_q, sy_d, gp_q, gp_d, lc_q, lc_d;
  err_t err_n;
  coord_t x_n, y_n;
  logic gp_rise;
  bresenham_step u_step (
    .err(err_q), .dx(dx_q), .dy(dy_q), .sx(sx_q), .sy(sy_q),
    .x(x_q), .y(y_q), .err_n(err_n), .x_n(x_n), .y_n(y_n)
  );
  assign gp_rise = get_pixel & ~gp_q;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    x2_d = x2_q;
    y2_d = y2_q;
    dx_d = dx_q;
    dy_d = dy_q;
    err_d = err_q;
    sx_d = sx_q;
    sy_d = sy_q;
    gp_d = get_pixel;
    if (calculate) begin
      x_d = x1;
      y_d = y1;
      x2_d = x2;
      y2_d = y2;
      dx_d = err_t'(abs_diff(x1, x2));
      dy_d = -err_t'(abs_diff(y1, y2));
      sx_d = x1 < x2;
      sy_d = y1 < y2;
      err_d = err_t'(abs_diff(x1, x2)) - err_t'(abs_diff(y1, y2));
      state_d = (x1 == x2 && y1 == y2) ? DONE : RUN;
    end else if (state_q == RUN && gp_rise) begin
      x_d = x_n;
      y_d = y_n;
      err_d = err_n;
      state_d = (x_n == x2_q && y_n == y2_q) ? DONE : RUN;
    end
    lc_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      x2_q <= '0;
      y2_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      err_q <= '0;
      sx_q <= 1'b0;
      sy_q <= 1'b0;
      gp_q <= 1'b0;
      lc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      x2_q <= x2_d;
      y2_q <= y2_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      err_q <= err_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      gp_q <= gp_d;
      lc_q <= lc_d;
    end
  end
  assign x_o = x_q;
  assign y_o = y_q;
  assign line_complete = lc_q;
endmodule

// File: tb/tb_draw_line.sv
// tb_draw_line: directed checks of the line rasterizer across octants and edge cases.
module tb_draw_line;
  logic clk = 1'b0;
  logic reset, calculate, get_pixel;
  logic [15:0] x1, y1, x2, y2, x_o, y_o;
  logic line_complete;
  int checks = 0;
  int errors = 0;
  int rises;
  logic [15:0] prev;

  draw_line dut (
    .clk(clk), .reset(reset), .calculate(calculate),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .get_pixel(get_pixel),
    .x_o(x_o), .y_o(y_o), .line_complete(line_complete)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pix(input string tag, input int ex, input int ey, input logic elc);
    chk({tag, ".x"}, {16'd0, x_o}, ex);
    chk({tag, ".y"}, {16'd0, y_o}, ey);
    chk({tag, ".lc"}, {31'd0, line_complete}, {31'd0, elc});
  endtask

  task automatic load(input int ax, input int ay, input int bx, input int by);
    x1 = 16'(ax); y1 = 16'(ay); x2 = 16'(bx); y2 = 16'(by);
    calculate = 1'b1;
    @(negedge clk);
    calculate = 1'b0;
  endtask

  task automatic step();
    get_pixel = 1'b1;
    @(negedge clk);
    get_pixel = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; calculate = 1'b0; get_pixel = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    #1;
    pix("reset", 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step();
    pix("idle_ignore", 0, 0, 1'b0);

    // Shallow line, x decreasing, y increasing
    load(100, 90, 50, 100);
    pix("shallow_first", 100, 90, 1'b0);
    rises = 0;
    for (int i = 1; i <= 50; i++) begin
      prev = y_o;
      step();
      chk("shallow_x", {16'd0, x_o}, 100 - i);
      if (y_o != prev) rises++;
      if (i == 1) pix("shallow_s1", 99, 90, 1'b0);
      if (i == 3) pix("shallow_s3", 97, 91, 1'b0);
      if (i == 8) pix("shallow_s8", 92, 92, 1'b0);
      if (i == 25) pix("shallow_s25", 75, 95, 1'b0);
      if (i == 49) pix("shallow_s49", 51, 100, 1'b0);
    end
    chk("shallow_yrises", rises, 10);
    pix("shallow_end", 50, 100, 1'b1);
    step();
    step();
    pix("shallow_hold", 50, 100, 1'b1);

    // Steep line, y decreasing, x increasing
    load(90, 100, 100, 50);
    pix("steep_first", 90, 100, 1'b0);
    rises = 0;
    for (int i = 1; i <= 50; i++) begin
      prev = x_o;
      step();
      chk("steep_y", {16'd0, y_o}, 100 - i);
      if (x_o != prev) rises++;
      if (i == 3) pix("steep_s3", 91, 97, 1'b0);
      if (i == 49) chk("steep_s49_lc", {31'd0, line_complete}, 0);
    end
    chk("steep_xrises", rises, 10);
    pix("steep_end", 100, 50, 1'b1);

    // Horizontal line; first request held high for 3 cycles advances once
    load(10, 50, 20, 50);
    pix("horiz_first", 10, 50, 1'b0);
    get_pixel = 1'b1;
    repeat (3) @(negedge clk);
    get_pixel = 1'b0;
    @(negedge clk);
    pix("horiz_held", 11, 50, 1'b0);
    for (int i = 2; i <= 10; i++) begin
      step();
      pix("horiz", 10 + i, 50, i == 10);
    end

    // Single point line
    load(10, 5, 10, 5);
    pix("point", 10, 5, 1'b1);
    repeat (2) begin
      get_pixel = 1'b1;
      repeat (2) @(negedge clk);
      get_pixel = 1'b0;
      @(negedge clk);
    end
    pix("point_hold", 10, 5, 1'b1);

    // Diagonal, both coordinates move every step
    load(30, 10, 20, 20);
    pix("diag_first", 30, 10, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step();
      pix("diag", 30 - i, 10 + i, i == 10);
    end

    // Asynchronous reset mid-line
    load(100, 90, 50, 100);
    step();
    step();
    pix("pre_reset", 98, 90, 1'b0);
    #1 reset = 1'b1;
    #1 pix("async_reset", 0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step();
    pix("post_reset_idle", 0, 0, 1'b0);

    // Restart while running
    load(90, 100, 100, 50);
    step();
    step();
    pix("run_pre", 90, 98, 1'b0);
    load(10, 50, 20, 50);
    pix("restart", 10, 50, 1'b0);
    step();
    pix("restart_s1", 11, 50, 1'b0);

    // calculate wins over a same-cycle get_pixel rise
    get_pixel = 1'b1;
    load(30, 10, 20, 20);
    get_pixel = 1'b0;
    @(negedge clk);
    pix("calc_priority", 30, 10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
